mem_wb_stage: RTL



---
 rtl/mem_wb_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: final pipeline stage. Register write-back for ALU results,
// data-memory loads/stores over a request/acknowledge handshake, with a
// bounded wait that aborts the access and flags WB_err on timeout.
module mem_wb_stage #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [0:5]        EX_function_bit,
   input  logic [0:4]        EX_rD,
   input  logic [0:4]        EX_PPPWW,
   input  logic [0:63]       EX_result,
   input  logic [0:63]       EX_store_data,
   input  logic              EX_wb_en,
   input  logic              EX_wmem_en,
   output logic [0:ADDR_W-1] DM_addr,
   output logic              DM_rd_en,
   output logic              DM_wr_en,
   output logic [0:63]       DM_wdata,
   input  logic [0:63]       DM_rdata,
   input  logic              DM_ack,
   output logic              WB_en,
   output logic [0:4]        WB_rD,
   output logic [0:4]        WB_PPPWW,
   output logic [0:63]       WB_data,
   output logic              WB_stall,
   output logic              WB_err
);

   typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [0:4]        ld_rd_q, ld_rd_d;
   logic [0:4]        ld_pppww_q, ld_pppww_d;
   logic [0:ADDR_W-1] dm_addr_q, dm_addr_d;
   logic              dm_rd_en_q, dm_rd_en_d;
   logic              dm_wr_en_q, dm_wr_en_d;
   logic [0:63]       dm_wdata_q, dm_wdata_d;
   logic              wb_en_q, wb_en_d;
   logic [0:4]        wb_rd_q, wb_rd_d;
   logic [0:4]        wb_pppww_q, wb_pppww_d;
   logic [0:63]       wb_data_q, wb_data_d;
   logic              wb_err_q, wb_err_d;

   logic              is_store, is_load, is_alu, timeout_hit;
   logic              unused_addr_hi;

   // Upper address bits are discarded by design.
   assign unused_addr_hi = ^EX_result[0:63-ADDR_W];

   // Instruction decode; a set memory-write flag forces a store.
   always_comb begin
      is_store    = (EX_function_bit == 6'b100000) || EX_wmem_en;
      is_load     = !is_store && (EX_function_bit == 6'b010000);
      is_alu      = !is_store && (EX_function_bit[0:1] == 2'b00) && EX_wb_en;
      timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
   end

   // Next-state and next-output computation; ack takes priority over timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_rd_d    = ld_rd_q;
      ld_pppww_d = ld_pppww_q;
      dm_addr_d  = dm_addr_q;
      dm_rd_en_d = dm_rd_en_q;
      dm_wr_en_d = dm_wr_en_q;
      dm_wdata_d = dm_wdata_q;
      wb_en_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_pppww_d = wb_pppww_q;
      wb_data_d  = wb_data_q;
      wb_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_store) begin
               dm_addr_d  = EX_result[64-ADDR_W:63];
               dm_wdata_d = EX_store_data;
               dm_wr_en_d = 1'b1;
               cnt_d      = '0;
               state_d    = ST_WAIT;
            end else if (is_load) begin
               dm_addr_d  = EX_result[64-ADDR_W:63];
               dm_rd_en_d = 1'b1;
               ld_rd_d    = EX_rD;
               ld_pppww_d = EX_PPPWW;
               cnt_d      = '0;
               state_d    = LD_WAIT;
            end else if (is_alu) begin
               wb_en_d    = (EX_rD != '0);
               wb_rd_d    = EX_rD;
               wb_pppww_d = EX_PPPWW;
               wb_data_d  = EX_result;
            end
         end
         LD_WAIT: begin
            if (DM_ack) begin
               dm_rd_en_d = 1'b0;
               wb_en_d    = (ld_rd_q != '0);
               wb_rd_d    = ld_rd_q;
               wb_pppww_d = ld_pppww_q;
               wb_data_d  = DM_rdata;
               state_d    = IDLE;
            end else if (timeout_hit) begin
               dm_rd_en_d = 1'b0;
               wb_err_d   = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_WAIT: begin
            if (DM_ack) begin
               dm_wr_en_d = 1'b0;
               state_d    = IDLE;
            end else if (timeout_hit) begin
               dm_wr_en_d = 1'b0;
               wb_err_d   = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            dm_rd_en_d = 1'b0;
            dm_wr_en_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ld_rd_q    <= '0;
         ld_pppww_q <= '0;
         dm_addr_q  <= '0;
         dm_rd_en_q <= 1'b0;
         dm_wr_en_q <= 1'b0;
         dm_wdata_q <= '0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_pppww_q <= '0;
         wb_data_q  <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_rd_q    <= ld_rd_d;
         ld_pppww_q <= ld_pppww_d;
         dm_addr_q  <= dm_addr_d;
         dm_rd_en_q <= dm_rd_en_d;
         dm_wr_en_q <= dm_wr_en_d;
         dm_wdata_q <= dm_wdata_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_pppww_q <= wb_pppww_d;
         wb_data_q  <= wb_data_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign DM_addr  = dm_addr_q;
   assign DM_rd_en = dm_rd_en_q;
   assign DM_wr_en = dm_wr_en_q;
   assign DM_wdata = dm_wdata_q;
   assign WB_en    = wb_en_q;
   assign WB_rD    = wb_rd_q;
   assign WB_PPPWW = wb_pppww_q;
   assign WB_data  = wb_data_q;
   assign WB_err   = wb_err_q;
   assign WB_stall = (state_q != IDLE);

endmodule
